// File: rtl/drv_pkg.sv
// Shared types and defaults for the driver ramp controller.
package drv_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RAMP_UP   = 3'd1,
      RUN       = 3'd2,
      RAMP_DOWN = 3'd3,
      FAULT     = 3'd4
   } ramp_state_t;

   localparam int DEF_TICK_DIV = 125000;

   function automatic logic is_active(input ramp_state_t s);
      return (s == RAMP_UP) || (s == RUN) || (s == RAMP_DOWN);
   endfunction

endpackage

// File: rtl/drv_slew.sv
// One slew-limited channel: steps value toward target (or toward 0 when zero is set) on each tick.
module drv_slew
   import drv_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] target,
   input  logic [W-1:0] step,
   input  logic         tick,
   input  logic         zero,
   input  logic         clr,
   output logic [W-1:0] value,
   output logic         eq
);

   logic [W-1:0] value_q, value_d, goal;
   logic [W:0]   sum_up, diff_dn;

   always_comb begin
      goal    = zero ? '0 : target;
      sum_up  = {1'b0, value_q} + {1'b0, step};
      diff_dn = {1'b0, value_q} - {1'b0, step};
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (tick && (value_q != goal)) begin
         // Extra bit catches overshoot/borrow so a large step lands on the goal instead of wrapping.
         if (step == '0) begin
            value_d = goal;
         end else if (goal > value_q) begin
            value_d = (sum_up >= {1'b0, goal}) ? goal : sum_up[W-1:0];
         end else begin
            value_d = (diff_dn[W] || (diff_dn <= {1'b0, goal})) ? goal : diff_dn[W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
   assign eq    = (value_q == goal);

endmodule

// File: rtl/drv_ramp_ctrl.sv
// Soft-start/soft-stop sequencer for fixed_driver: FSM, ramp tick prescaler, two slew channels.
// Define DRV_RAMP_WATCHDOG_EN to auto ramp down after WDT_TICKS ticks with link_ok low.
module drv_ramp_ctrl
   import drv_pkg::*;
#(
   parameter int FREQ_W    = 32,
   parameter int DUTY_W    = 16,
   parameter int TICK_DIV  = DEF_TICK_DIV,
   parameter int WDT_TICKS = 500
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              estop,
   input  logic              fault_clr,
   input  logic              link_ok,
   input  logic [FREQ_W-1:0] tgt_freq,
   input  logic [DUTY_W-1:0] tgt_duty,
   input  logic [FREQ_W-1:0] freq_step,
   input  logic [DUTY_W-1:0] duty_step,
   output logic [FREQ_W-1:0] out_freq,
   output logic [DUTY_W-1:0] out_duty,
   output logic              out_en,
   output logic              at_target,
   output logic              busy,
   output logic              fault,
   output logic [2:0]        state
);

   localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);

   ramp_state_t    state_q, state_d;
   logic           out_en_q, out_en_d, busy_q, busy_d, fault_q, fault_d;
   logic           at_target_q, at_target_d;
   logic [TCW-1:0] tcnt_q, tcnt_d;
   logic           tick, wdt_trip, freq_eq, duty_eq, both_eq, ch_clr, ch_zero;

   always_comb begin
      tick   = (tcnt_q == TICK_LAST);
      tcnt_d = tick ? '0 : tcnt_q + TCW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end

`ifdef DRV_RAMP_WATCHDOG_EN
   localparam int WCW = $clog2(WDT_TICKS + 1);
   logic [WCW-1:0] wdt_q, wdt_d;

   always_comb begin
      wdt_d = wdt_q;
      if (link_ok || !((state_q == RAMP_UP) || (state_q == RUN))) begin
         wdt_d = '0;
      end else if (tick && (wdt_q != WCW'(WDT_TICKS))) begin
         wdt_d = wdt_q + WCW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdt_q <= '0;
      end else begin
         wdt_q <= wdt_d;
      end
   end

   assign wdt_trip = (wdt_q == WCW'(WDT_TICKS));
`else
   logic unused_link;
   assign unused_link = link_ok ^ (WDT_TICKS == 0);
   assign wdt_trip    = 1'b0;
`endif

   // estop clears the channels on the same edge it is sampled, independent of tick phase.
   assign ch_clr  = estop || (state_q == IDLE) || (state_q == FAULT);
   assign ch_zero = (state_q == RAMP_DOWN);
   assign both_eq = freq_eq && duty_eq;

   drv_slew #(.W(FREQ_W)) u_freq (
      .clk(clk), .rst(rst), .target(tgt_freq), .step(freq_step), .tick(tick),
      .zero(ch_zero), .clr(ch_clr), .value(out_freq), .eq(freq_eq)
   );

   drv_slew #(.W(DUTY_W)) u_duty (
      .clk(clk), .rst(rst), .target(tgt_duty), .step(duty_step), .tick(tick),
      .zero(ch_zero), .clr(ch_clr), .value(out_duty), .eq(duty_eq)
   );

   always_comb begin
      state_d = state_q;
      if (estop) begin
         state_d = FAULT;
      end else begin
         case (state_q)
            IDLE:      if (!stop && start) state_d = RAMP_UP;
            RAMP_UP:   if (stop || wdt_trip) state_d = RAMP_DOWN;
                       else if (both_eq) state_d = RUN;
            RUN:       if (stop || wdt_trip) state_d = RAMP_DOWN;
            RAMP_DOWN: if (!stop && start) state_d = RAMP_UP;
                       else if (both_eq) state_d = IDLE;
            FAULT:     if (fault_clr && !start) state_d = IDLE;
            default:   state_d = IDLE;
         endcase
      end
      out_en_d    = !estop && is_active(state_q);
      busy_d      = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
      fault_d     = (state_q == FAULT);
      at_target_d = (state_q == RUN) && both_eq;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         out_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         fault_q     <= 1'b0;
         at_target_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_en_q    <= out_en_d;
         busy_q      <= busy_d;
         fault_q     <= fault_d;
         at_target_q <= at_target_d;
      end
   end

   assign out_en    = out_en_q;
   assign busy      = busy_q;
   assign fault     = fault_q;
   assign at_target = at_target_q;
   assign state     = state_q;

endmodule

// File: tb/tb_drv_ramp_ctrl.sv
// Scoreboard bench for drv_ramp_ctrl: expected output pairs queued by stimulus, checked on every value change.
module tb_drv_ramp_ctrl;
   import drv_pkg::*;

   localparam int FW = 32;
   localparam int DW = 16;

   typedef struct packed {
      logic [FW-1:0] f;
      logic [DW-1:0] d;
   } pair_t;

   logic          clk = 1'b0, rst = 1'b1;
   logic          start = 1'b0, stop = 1'b0, estop = 1'b0, fault_clr = 1'b0, link_ok = 1'b1;
   logic [FW-1:0] tgt_freq = '0, freq_step = '0;
   logic [DW-1:0] tgt_duty = '0, duty_step = '0;
   logic [FW-1:0] out_freq;
   logic [DW-1:0] out_duty;
   logic          out_en, at_target, busy, fault;
   logic [2:0]    state;

   int    n_cmp = 0;
   int    n_bad = 0;
   pair_t exp_q[$];

   always #5 clk = ~clk;

   drv_ramp_ctrl #(.FREQ_W(FW), .DUTY_W(DW), .TICK_DIV(4), .WDT_TICKS(3)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .estop(estop),
      .fault_clr(fault_clr), .link_ok(link_ok), .tgt_freq(tgt_freq), .tgt_duty(tgt_duty),
      .freq_step(freq_step), .duty_step(duty_step), .out_freq(out_freq), .out_duty(out_duty),
      .out_en(out_en), .at_target(at_target), .busy(busy), .fault(fault), .state(state)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [FW-1:0] f, input logic [DW-1:0] d);
      exp_q.push_back({f, d});
   endtask

   task automatic wait_state(input logic [2:0] s, input int max, input string name);
      int i = 0;
      while (state !== s && i < max) begin
         @(negedge clk);
         i++;
      end
      chk(name, state, s);
   endtask

   task automatic wait_freq(input logic [FW-1:0] f, input int max, input string name);
      int i = 0;
      while (out_freq !== f && i < max) begin
         @(negedge clk);
         i++;
      end
      chk(name, out_freq, f);
   endtask

   // Monitor: every change of the applied pair must match the next queued expectation.
   initial begin
      pair_t prev, cur, e;
      prev = '0;
      forever begin
         @(negedge clk);
         cur = {out_freq, out_duty};
         if (!rst && cur != prev) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL values: unexpected change to %0d/%0d", cur.f, cur.d);
            end else begin
               e = exp_q.pop_front();
               if (cur != e) begin
                  n_bad++;
                  $display("FAIL values: got %0d/%0d, expected %0d/%0d", cur.f, cur.d, e.f, e.d);
               end
            end
         end
         prev = cur;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, compared %0d", n_cmp);
      $fatal(1, "timeout");
   end

   initial begin
      int i;
      cyc(2);
      chk("rst_freq", out_freq, 0);
      chk("rst_duty", out_duty, 0);
      chk("rst_state", state, IDLE);
      chk("rst_out_en", out_en, 0);
      chk("rst_at_target", at_target, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fault", fault, 0);
      rst = 1'b0;
      cyc(1);

      // Ramp up to 1000/50
      tgt_freq = 1000; freq_step = 300; tgt_duty = 50; duty_step = 20;
      push(300, 20); push(600, 40); push(900, 50); push(1000, 50);
      start = 1'b1;
      wait_state(RAMP_UP, 4, "start_to_ramp_up");
      chk("out_en_lag", out_en, 0);
      start = 1'b0;
      cyc(1);
      chk("out_en_on", out_en, 1);
      chk("busy_up", busy, 1);
      wait_state(RUN, 30, "reach_run");
      cyc(2);
      chk("run_at_target", at_target, 1);
      chk("run_busy", busy, 0);
      chk("run_freq", out_freq, 1000);

      // Retarget duty in RUN
      push(1000, 30);
      tgt_duty = 30;
      cyc(1);
      chk("retarget_state", state, RUN);
      chk("retarget_drop", at_target, 0);
      i = 0;
      while (at_target !== 1'b1 && i < 20) begin
         @(negedge clk);
         i++;
      end
      chk("retarget_settle", at_target, 1);

      // Stop from 1000/30
      push(700, 10); push(400, 0); push(100, 0); push(0, 0);
      stop = 1'b1;
      wait_state(RAMP_DOWN, 4, "stop_to_ramp_down");
      wait_state(IDLE, 40, "stop_to_idle");
      cyc(1);
      chk("stop_out_en", out_en, 0);
      stop = 1'b0;
      cyc(2);

      // Emergency stop mid ramp-up
      push(300, 20); push(0, 0);
      start = 1'b1;
      wait_state(RAMP_UP, 4, "estop_start");
      start = 1'b0;
      wait_freq(300, 10, "estop_pre");
      estop = 1'b1;
      cyc(1);
      chk("estop_state", state, FAULT);
      chk("estop_out_en", out_en, 0);
      chk("estop_freq", out_freq, 0);
      chk("estop_duty", out_duty, 0);
      cyc(1);
      chk("estop_fault", fault, 1);
      fault_clr = 1'b1;
      cyc(1);
      fault_clr = 1'b0;
      cyc(1);
      chk("fault_hold", state, FAULT);
      estop = 1'b0;
      cyc(1);
      fault_clr = 1'b1;
      cyc(1);
      fault_clr = 1'b0;
      chk("fault_clr_idle", state, IDLE);
      cyc(1);
      chk("fault_cleared", fault, 0);

      // start+stop together, then jump with step 0
      start = 1'b1; stop = 1'b1;
      cyc(3);
      chk("start_stop_idle", state, IDLE);
      chk("start_stop_en", out_en, 0);
      tgt_freq = 32'hFFFF_FFFF; freq_step = 0; tgt_duty = 7; duty_step = 0;
      push(32'hFFFF_FFFF, 7);
      stop = 1'b0;
      wait_state(RAMP_UP, 4, "jump_start");
      start = 1'b0;
      wait_state(RUN, 12, "jump_run");
      chk("jump_freq", out_freq, 32'hFFFF_FFFF);
      push(0, 0);
      stop = 1'b1;
      wait_state(IDLE, 20, "jump_idle");
      stop = 1'b0;
      cyc(2);

      // Restart during ramp-down at 600
      tgt_freq = 1200; freq_step = 300; tgt_duty = 40; duty_step = 10;
      push(300, 10); push(600, 20); push(900, 30); push(1200, 40);
      start = 1'b1;
      wait_state(RAMP_UP, 4, "restart_start");
      start = 1'b0;
      wait_state(RUN, 30, "restart_run");
      push(900, 30); push(600, 20);
      stop = 1'b1;
      wait_freq(600, 20, "down_to_600");
      chk("down_state", state, RAMP_DOWN);
      push(900, 30); push(1200, 40);
      stop = 1'b0; start = 1'b1;
      wait_state(RAMP_UP, 4, "restart_up");
      chk("restart_from", out_freq, 600);
      start = 1'b0;
      wait_state(RUN, 20, "restart_run2");
      chk("restart_final", out_freq, 1200);
      push(900, 30); push(600, 20); push(300, 10); push(0, 0);
      stop = 1'b1;
      wait_state(IDLE, 40, "restart_idle");
      stop = 1'b0;
      cyc(2);

`ifdef DRV_RAMP_WATCHDOG_EN
      // Link watchdog: a link_ok pulse restarts the count
      tgt_freq = 300; freq_step = 0; tgt_duty = 10; duty_step = 0;
      push(300, 10);
      start = 1'b1;
      wait_state(RAMP_UP, 4, "wdt_start");
      start = 1'b0;
      wait_state(RUN, 12, "wdt_run");
      link_ok = 1'b0;
      cyc(6);
      chk("wdt_early", state, RUN);
      link_ok = 1'b1;
      cyc(1);
      link_ok = 1'b0;
      cyc(8);
      chk("wdt_count_reset", state, RUN);
      push(0, 0);
      wait_state(RAMP_DOWN, 8, "wdt_trip");
      wait_state(IDLE, 12, "wdt_idle");
      link_ok = 1'b1;
      cyc(2);
`endif

      cyc(3);
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/drv_ramp_ctrl.md
# drv_ramp_ctrl

Soft-start/soft-stop sequencer between `p10_ctrl` and `fixed_driver`. It takes the host-requested frequency and duty and ramps the values applied to the driver at a bounded slew rate. It also owns the driver enable, sequences start, stop and emergency stop, and optionally stops the drive when the TCP link drops.

## Interface

Parameters:
- `FREQ_W`, 32: frequency word width (Hz, matches `FREQ_STEP_HZ = 1`).
- `DUTY_W`, 16: duty word width (units of `DUTY_SCALE`).
- `TICK_DIV`, 125000: `clk` cycles per ramp tick (1 kHz at 125 MHz); ≥ 2.
- `WDT_TICKS`, 500: ramp ticks with the link down before auto-stop (watchdog build only).

Ports:
- `clk` in 1: system clock (`phy_rx_clk` domain).
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level; request run.
- `stop` in 1: level; request controlled ramp-down.
- `estop` in 1: level; immediate shutdown, latches FAULT.
- `fault_clr` in 1: pulse; leave FAULT.
- `link_ok` in 1: TCP connected status.
- `tgt_freq` in `FREQ_W`: target frequency.
- `tgt_duty` in `DUTY_W`: target duty.
- `freq_step` in `FREQ_W`: frequency change per tick; 0 means jump.
- `duty_step` in `DUTY_W`: duty change per tick; 0 means jump.
- `out_freq` out `FREQ_W`: applied frequency.
- `out_duty` out `DUTY_W`: applied duty.
- `out_en` out 1: driver enable.
- `at_target` out 1: outputs equal the targets in RUN.
- `busy` out 1: state is RAMP_UP or RAMP_DOWN.
- `fault` out 1: state is FAULT.
- `state` out 3: `ramp_state_t` encoding, for status readback.

## Operation

- States: IDLE, RAMP_UP, RUN, RAMP_DOWN, FAULT.
- Input priority each cycle: `estop` > `stop` > `start`.
- `estop` from any state → FAULT. On entry, `out_freq`, `out_duty` and `out_en` are zeroed.
- FAULT → IDLE on `fault_clr` only when `estop` = 0 and `start` = 0; otherwise FAULT is held.
- IDLE: outputs 0, `out_en` = 0.
  - `start` → RAMP_UP; `out_en` = 1 from the next cycle.
- RAMP_UP / RUN: on each tick, each channel moves toward its target by `min(step, |target − out|)`, or jumps to the target when `step` = 0.
  - RAMP_UP → RUN when both channels equal their targets.
  - In RUN, a target change re-ramps in place: the state stays RUN and `at_target` drops.
- `stop` in RAMP_UP or RUN → RAMP_DOWN. Both channels ramp toward 0 with the same step rules.
  - When both reach 0 → IDLE; `out_en` drops on that transition.
- `start` in RAMP_DOWN with `stop` = 0 → RAMP_UP from the current values, with no reset to 0.
- Arithmetic: differences are computed at width+1 and clamped, so there is no wrap. A step larger than the remaining distance lands exactly on the target. Targets are unsigned.
- `at_target` = (state == RUN) && both channels equal their targets.

## Timing

- Reset values: state IDLE, `out_freq` = 0, `out_duty` = 0, `out_en` = 0, `at_target` = 0, `busy` = 0, `fault` = 0, tick counter = 0.
- Tick: one-cycle internal pulse every `TICK_DIV` cycles, free-running from reset release.
- All outputs are registered. Channel values update in the cycle after a tick.
- Control latency: the state changes on the first edge with the input high. `out_en`, `busy` and `fault` follow one cycle later.
- `estop`: `out_en` = 0 and both values = 0 exactly one cycle after `estop` is sampled high, regardless of tick phase.
- A target change mid-ramp is honoured at the next tick.
- Reset asserted mid-ramp forces all outputs to reset values immediately (asynchronous).

## Configuration

- `DRV_RAMP_WATCHDOG_EN` defined:
  - While in RAMP_UP or RUN with `link_ok` = 0, a tick counter runs.
  - The counter clears when `link_ok` = 1.
  - At `WDT_TICKS` the block enters RAMP_DOWN, exactly as for `stop`.
- Not defined: `link_ok` is ignored and the watchdog logic is absent.

## Structure

- `drv_pkg` holds:
  - `ramp_state_t` enum (IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, FAULT=4).
  - Default `TICK_DIV` constant.
- Sub-module `drv_slew` (parameter `W`): one channel.
  - Inputs: `target`, `step`, `tick`, `zero` (force 0), `clr`.
  - Outputs: `value`, `eq`.
  - Instantiated twice, once for frequency and once for duty.
- FSM, tick prescaler and watchdog live in `drv_ramp_ctrl`.

## Test plan

All scenarios use `TICK_DIV` = 4.
- **Ramp up:** `start` with `tgt_freq` = 1000, `freq_step` = 300, `tgt_duty` = 50, `duty_step` = 20 → freq sequence 300, 600, 900, 1000 and duty sequence 20, 40, 50, 50 on successive ticks. RUN entered after the 4th tick; `at_target` = 1.
- **Stop:** `stop` in RUN at 1000/50 → values decrease by their steps down to 0/0, then IDLE with `out_en` = 0.
- **Emergency stop:** `estop` mid-RAMP_UP → next cycle `out_en` = 0 and values 0/0, `fault` = 1.
  - `fault_clr` while `estop` = 1 → remains in FAULT.
  - After `estop` is released, `fault_clr` → IDLE.
- **Simultaneous inputs and jump:** `start` and `stop` together in IDLE → stays IDLE. With `step` = 0 and `tgt_freq` = 0xFFFFFFFF → value jumps to 0xFFFFFFFF in one tick, with no wrap.
- **Restart during ramp-down:** `start` in RAMP_DOWN at freq 600 → RAMP_UP resumes from 600 toward the target.
- **Watchdog:** with `DRV_RAMP_WATCHDOG_EN` defined, `WDT_TICKS` = 3, and `link_ok` low in RUN → RAMP_DOWN after 3 ticks. A `link_ok` high pulse before the 3rd tick resets the count.
